// File: rtl/rr_mux_arbiter_4x1.sv
// rtl/rr_mux_arbiter_4x1.sv - round-robin arbiter owning the select of a shared 4x1 mux
module rr_mux_arbiter_4x1 #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    output logic [3:0]       gnt,
    output logic [1:0]       sel,
    output logic             valid,
    output logic [WIDTH-1:0] y
);

    // hold_cnt needs at least one bit even when MAX_HOLD is 1
    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    last, last_nxt;
    logic [CW-1:0] hold_cnt, hold_nxt;
    logic [3:0]    gnt_nxt;
    logic [1:0]    sel_nxt;
    logic          valid_nxt;

    logic [1:0]    pick;
    logic [1:0]    pick_idx;
    logic          pick_found;
    logic          release_now;

    // Rotating search starting just after the most recent owner; the owner itself is tried last
    always_comb begin
        pick       = last;
        pick_idx   = last;
        pick_found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            pick_idx = last + 2'(i);
            if (!pick_found && req[pick_idx]) begin
                pick       = pick_idx;
                pick_found = 1'b1;
            end
        end
    end

    // Current owner gives up the mux when it stops requesting or its hold window is used up
    always_comb begin
        release_now = (!req[sel]) || (hold_cnt == HOLD_LAST);
    end

    // State register: grant, select, rotation pointer and hold counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            sel      <= 2'b00;
            valid    <= 1'b0;
            last     <= 2'b11;
            hold_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            sel      <= sel_nxt;
            valid    <= valid_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
        end
    end

    // Next-state: grant from idle, extend the current grant, or hand off in the same edge
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        sel_nxt   = sel;
        valid_nxt = valid;
        last_nxt  = last;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_nxt = GRANT;
                    gnt_nxt   = 4'b0001 << pick;
                    sel_nxt   = pick;
                    last_nxt  = pick;
                    valid_nxt = 1'b1;
                    hold_nxt  = '0;
                end
            end
            GRANT: begin
                if (!release_now) begin
                    hold_nxt = hold_cnt + 1'b1;
                end else if (req != 4'b0000) begin
                    // last already equals the releasing owner, so pick rotates away from it
                    gnt_nxt   = 4'b0001 << pick;
                    sel_nxt   = pick;
                    last_nxt  = pick;
                    valid_nxt = 1'b1;
                    hold_nxt  = '0;
                end else begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                    valid_nxt = 1'b0;
                    hold_nxt  = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
                valid_nxt = 1'b0;
                hold_nxt  = '0;
            end
        endcase
    end

    // Output mux: selected input while a grant is active, zero otherwise
    always_comb begin
        y = '0;
        if (valid) begin
            case (sel)
                2'd0:    y = i0;
                2'd1:    y = i1;
                2'd2:    y = i2;
                default: y = i3;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter_4x1.sv
// tb/tb_rr_mux_arbiter_4x1.sv - scoreboard bench for rr_mux_arbiter_4x1
module tb_rr_mux_arbiter_4x1;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req;
    logic [WIDTH-1:0] i0, i1, i2, i3;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic             valid;
    logic [WIDTH-1:0] y;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] sel;
        string      name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;
    bit   done = 1'b0;

    rr_mux_arbiter_4x1 #(.WIDTH(WIDTH), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .i0    (i0),
        .i1    (i1),
        .i2    (i2),
        .i3    (i3),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid),
        .y     (y)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] exp_y(input logic [1:0] s, input logic v);
        if (!v) return '0;
        case (s)
            2'd0:    return 8'hA0;
            2'd1:    return 8'hB1;
            2'd2:    return 8'hC2;
            default: return 8'hD3;
        endcase
    endfunction

    task automatic check_outputs(input string name, input logic [3:0] eg, input logic [1:0] es);
        logic             ev;
        logic [WIDTH-1:0] ey;
        ev = (eg != 4'b0000);
        ey = exp_y(es, ev);
        checks++;
        if (gnt !== eg || sel !== es || valid !== ev || y !== ey) begin
            errors++;
            $display("FAIL %s: got gnt=%b sel=%0d valid=%b y=%h, want gnt=%b sel=%0d valid=%b y=%h",
                     name, gnt, sel, valid, y, eg, es, ev, ey);
        end
    endtask

    // Apply one request vector for the coming edge and queue the outputs expected after it
    task automatic step(input string name, input logic [3:0] r, input logic [3:0] eg, input logic [1:0] es);
        exp_t e;
        @(negedge clk);
        req = r;
        e.gnt  = eg;
        e.sel  = es;
        e.name = $sformatf("%s#%0d", name, step_no);
        step_no++;
        q.push_back(e);
    endtask

    // Monitor: after every edge, compare against the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check_outputs(e.name, e.gnt, e.sel);
            end
        end
    end

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        i0  = 8'hA0;
        i1  = 8'hB1;
        i2  = 8'hC2;
        i3  = 8'hD3;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset_state", 4'b0000, 2'd0);
        @(negedge clk);
        rst = 1'b0;

        // idle after reset with no requests
        step("idle", 4'b0000, 4'b0000, 2'd0);
        step("idle", 4'b0000, 4'b0000, 2'd0);

        // fairness after reset: 0 first, 4-cycle timeout, then 3
        for (int k = 0; k < 4; k++) step("fair0", 4'b1001, 4'b0001, 2'd0);
        step("fair3", 4'b1001, 4'b1000, 2'd3);
        step("to_idle", 4'b0000, 4'b0000, 2'd3);

        // single requester held 2 cycles, then dropped; sel holds in idle
        step("single", 4'b0100, 4'b0100, 2'd2);
        step("single", 4'b0100, 4'b0100, 2'd2);
        step("single_drop", 4'b0000, 4'b0000, 2'd2);
        step("single_drop", 4'b0000, 4'b0000, 2'd2);

        // all requesting: rotation continues from last=2, 4 cycles each, no gaps
        for (int k = 0; k < 4; k++) step("rot3", 4'b1111, 4'b1000, 2'd3);
        for (int k = 0; k < 4; k++) step("rot0", 4'b1111, 4'b0001, 2'd0);
        for (int k = 0; k < 4; k++) step("rot1", 4'b1111, 4'b0010, 2'd1);
        for (int k = 0; k < 4; k++) step("rot2", 4'b1111, 4'b0100, 2'd2);
        step("rot3b", 4'b1111, 4'b1000, 2'd3);

        // owner 3 drops, 0 takes over; then owner 0 drops with 3 waiting
        step("hand0", 4'b0001, 4'b0001, 2'd0);
        step("hand0", 4'b0001, 4'b0001, 2'd0);
        step("hand3", 4'b1000, 4'b1000, 2'd3);
        // non-owner requests do not disturb the current grant
        step("nonowner", 4'b1110, 4'b1000, 2'd3);
        step("hand1", 4'b0110, 4'b0010, 2'd1);

        // sole requester through several timeouts: grant never drops
        for (int k = 0; k < 10; k++) step("sole", 4'b0010, 4'b0010, 2'd1);

        // asynchronous reset mid-grant, checked between clock edges
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_outputs("async_rst", 4'b0000, 2'd0);
        @(posedge clk);
        #1;
        check_outputs("rst_held", 4'b0000, 2'd0);
        @(negedge clk);
        req = 4'b0000;
        rst = 1'b0;
        step("post_rst_idle", 4'b0000, 4'b0000, 2'd0);
        step("post_rst_idle", 4'b0000, 4'b0000, 2'd0);
        step("post_rst_prio", 4'b1111, 4'b0001, 2'd0);
        step("post_rst_prio", 4'b1111, 4'b0001, 2'd0);

        // let the monitor drain, bounded
        for (int k = 0; k < 20 && q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter_4x1.md
# rr_mux_arbiter_4x1

Round-robin arbiter that shares one 4x1 multiplexer between four requesters. It accepts a request vector, grants the mux to one requester at a time, and drives the mux select from the current grant. Each grant ends when the requester drops its request or when a bounded hold time expires. It sits in front of the existing 4x1 mux datapath and owns its select line.

## Interface
- WIDTH, 1, data width of each mux input and of y
- MAX_HOLD, 4, maximum consecutive cycles one grant may last (must be ≥ 1)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  4  request vector; req[n] requests input in
- i0, i1, i2, i3  input  WIDTH each  data inputs
- gnt  output  4  one-hot grant, registered; all-zero when idle
- sel  output  2  mux select, registered; equals index of the set gnt bit
- valid  output  1  registered; high while any grant is active
- y  output  WIDTH  data output; input selected by sel when valid=1, else all-zero (combinational from sel, valid and inputs)

## Operation
- Internal state: FSM {IDLE, GRANT}, last[1:0] (index of most recent grant), hold_cnt (counts 0..MAX_HOLD-1).
- Reset values: state=IDLE, gnt=4'b0000, sel=2'b00, valid=0, y=0, last=2'b11, hold_cnt=0. With last=3, priority after reset starts at requester 0.
- Round-robin pick: search req in order last+1, last+2, last+3, last (mod 4). The first set bit wins.
- IDLE state:
  - If req==0, remain in IDLE.
  - Otherwise, on the next edge: state=GRANT, gnt=onehot(pick), sel=pick, last=pick, valid=1, hold_cnt=0.
- GRANT state, current owner c=sel:
  - Release when req[c]==0 (voluntary release) or hold_cnt==MAX_HOLD-1 (timeout).
  - No release: hold_cnt increments; gnt and sel are unchanged.
  - On release, if req is nonzero: re-arbitrate in the same edge with last=c. The new owner is granted with no idle bubble and hold_cnt=0.
  - On release, if req==0: state=IDLE, gnt=0, valid=0. sel holds its value.
  - Timeout with only c still requesting: c is re-granted, hold_cnt=0. gnt stays high continuously.
- sel changes only on a grant edge. gnt is never multi-hot and never points at a requester whose req was low at the arbitration edge.
- Req changes from non-owners during GRANT do not affect the current grant.

## Timing
- Grant latency: a request sampled at edge k produces gnt, sel and valid at edge k (visible after k), i.e. 1 cycle from req assertion to grant.
- Voluntary release: owner drops req before edge k; at edge k the grant moves to the next requester or to IDLE.
- Maximum grant duration is MAX_HOLD cycles. With MAX_HOLD=1 the grant rotates every cycle among active requesters.
- y follows sel and valid combinationally within the cycle, with no extra latency.
- rst asserted at any time, including mid-grant: all outputs go to their reset values immediately, without waiting for clk. The first arbitration after rst deasserts uses priority 0 first.
- Simultaneous release and new requests are resolved at the same edge, using rotation from the just-released owner.

## Test plan
- Reset/idle: rst=1 mid-grant → gnt=0000, valid=0, y=0 immediately. Release rst with req=0000 → outputs stay at reset values.
- Single requester: req=0100 (WIDTH=1, {i3,i2,i1,i0}=0101), held 2 cycles then dropped → gnt=0100, sel=2, y=1 for 2 cycles, then gnt=0000, valid=0.
- Rotation with all requesting, MAX_HOLD=4: req=1111 held → grants 0001, 0010, 0100, 1000, 0001. Each lasts 4 cycles, with no gaps.
- Voluntary handoff: owner 0 drops req while req[3] is high → next edge gnt=1000, sel=3, with no idle cycle.
- Timeout with sole requester: req=0010 held for 10 cycles → gnt=0010 continuously. hold_cnt wraps every 4 cycles and sel never changes.
- Fairness after reset: req=1001 applied right after reset → requester 0 is granted first, then requester 3.
